// File: rtl/prog_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : prog_fetch
//  Purpose  : Program counter / instruction register sequencer for the prog
//             memory, with jump/call/return redirects and halt/run control.
//  Revision : 1.0  initial release
// ============================================================================
module prog_fetch #(
    parameter int p_size      = 6,
    parameter int i_size      = 24,
    parameter int stack_depth = 4
) (
    input  logic              clock,
    input  logic              reset,
    output logic [p_size-1:0] address,
    input  logic [i_size:0]   instr,
    output logic [i_size:0]   ir,
    output logic [p_size-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              jump,
    input  logic              call,
    input  logic              ret,
    input  logic [p_size-1:0] jump_addr,
    input  logic              halt,
    input  logic              run,
    output logic              halted,
    output logic              stack_err
);

    localparam int c_IDX_W = $clog2(stack_depth);
    localparam int c_SP_W  = c_IDX_W + 1;

    localparam logic [c_SP_W-1:0]  c_SP_FULL = c_SP_W'(stack_depth);
    localparam logic [c_SP_W-1:0]  c_SP_ONE  = c_SP_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE = c_IDX_W'(1);
    localparam logic [p_size-1:0]  c_PC_ONE  = p_size'(1);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_FETCH  = 2'd1;
    localparam logic [1:0] c_S_HALTED = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    logic [p_size-1:0] r_pc;
    logic [i_size:0]   r_ir;
    logic [p_size-1:0] r_ir_pc;
    logic              r_ir_valid;
    logic [c_SP_W-1:0] r_sp;
    logic              r_stack_err;
    logic [p_size-1:0] r_stack [stack_depth];

    logic              w_in_fetch;
    logic              w_consume;
    logic              w_can_load;
    logic              w_do_ret;
    logic              w_do_call;
    logic              w_do_jump;
    logic              w_do_halt;
    logic              w_do_load;
    logic              w_halted;
    logic              w_stack_empty;
    logic              w_stack_full;
    logic [c_IDX_W-1:0] w_rd_idx;
    logic [p_size-1:0] w_ret_addr;
    logic [p_size-1:0] w_link_addr;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (run) begin
                    w_state_nxt = c_S_FETCH;
                end
            end
            c_S_FETCH: begin
                if (w_do_halt) begin
                    w_state_nxt = c_S_HALTED;
                end
            end
            c_S_HALTED: begin
                if (run) begin
                    w_state_nxt = c_S_FETCH;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / action decode. Redirects are strictly prioritised
    // ret > call > jump > halt, so a halt riding with a redirect is dropped.
    // ------------------------------------------------------------------
    always_comb begin
        w_in_fetch = (r_state == c_S_FETCH);
        w_consume  = r_ir_valid && ir_ready;
        w_can_load = !r_ir_valid || ir_ready;
        w_do_ret   = w_in_fetch && w_consume && ret;
        w_do_call  = w_in_fetch && w_consume && call && !ret;
        w_do_jump  = w_in_fetch && w_consume && jump && !ret && !call;
        w_do_halt  = w_in_fetch && w_consume && halt && !ret && !call && !jump;
        w_do_load  = w_in_fetch && w_can_load
                     && !(w_consume && (ret || call || jump || halt));
        w_halted   = !w_in_fetch;
    end

    // ------------------------------------------------------------------
    // Return stack addressing. When sp==stack_depth the low index bits are
    // zero, so decrementing them still lands on the top entry.
    // ------------------------------------------------------------------
    assign w_stack_empty = (r_sp == '0);
    assign w_stack_full  = (r_sp >= c_SP_FULL);
    assign w_rd_idx      = r_sp[c_IDX_W-1:0] - c_IDX_ONE;
    assign w_ret_addr    = r_stack[w_rd_idx];
    assign w_link_addr   = r_ir_pc + c_PC_ONE;

    always_ff @(posedge clock) begin
        if (!reset && w_do_call && !w_stack_full) begin
            r_stack[r_sp[c_IDX_W-1:0]] <= w_link_addr;
        end
    end

    // ------------------------------------------------------------------
    // Program counter, instruction register and stack pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc        <= '0;
            r_ir        <= '0;
            r_ir_pc     <= '0;
            r_ir_valid  <= 1'b0;
            r_sp        <= '0;
            r_stack_err <= 1'b0;
        end else begin
            if (w_do_ret) begin
                if (w_stack_empty) begin
                    r_pc        <= '0;
                    r_stack_err <= 1'b1;
                end else begin
                    r_pc <= w_ret_addr;
                    r_sp <= r_sp - c_SP_ONE;
                end
                r_ir_valid <= 1'b0;
            end else if (w_do_call) begin
                if (w_stack_full) begin
                    r_stack_err <= 1'b1;
                end else begin
                    r_sp <= r_sp + c_SP_ONE;
                end
                r_pc       <= jump_addr;
                r_ir_valid <= 1'b0;
            end else if (w_do_jump) begin
                r_pc       <= jump_addr;
                r_ir_valid <= 1'b0;
            end else if (w_do_halt) begin
                r_ir_valid <= 1'b0;
            end else if (w_do_load) begin
                r_ir       <= instr;
                r_ir_pc    <= r_pc;
                r_ir_valid <= 1'b1;
                r_pc       <= r_pc + c_PC_ONE;
            end
        end
    end

    assign address   = r_pc;
    assign ir        = r_ir;
    assign ir_pc     = r_ir_pc;
    assign ir_valid  = r_ir_valid;
    assign halted    = w_halted;
    assign stack_err = r_stack_err;

endmodule
`default_nettype wire

// File: tb/tb_prog_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_fetch
//  Purpose  : Directed plus randomized self-checking bench for prog_fetch.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prog_fetch;

    localparam int c_DEPTH = 4;
    localparam int c_MEM   = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  address;
    logic [24:0] instr;
    logic [24:0] ir;
    logic [5:0]  ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        jump;
    logic        call;
    logic        ret;
    logic [5:0]  jump_addr;
    logic        halt;
    logic        run;
    logic        halted;
    logic        stack_err;

    logic [24:0] mem [c_MEM];

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    int          m_pc;
    logic [24:0] m_ir;
    int          m_ir_pc;
    bit          m_valid;
    bit          m_err;
    int          m_mode;      // 0 idle, 1 fetching, 2 halted
    int          m_stack[$];

    prog_fetch #(.p_size(6), .i_size(24), .stack_depth(c_DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .address   (address),
        .instr     (instr),
        .ir        (ir),
        .ir_pc     (ir_pc),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .jump      (jump),
        .call      (call),
        .ret       (ret),
        .jump_addr (jump_addr),
        .halt      (halt),
        .run       (run),
        .halted    (halted),
        .stack_err (stack_err)
    );

    assign instr = mem[address];

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs as they stand, then
    // clock the DUT and compare every visible output.
    task automatic tick();
        bit consume;
        if (reset) begin
            m_pc = 0; m_ir = '0; m_ir_pc = 0; m_valid = 0; m_err = 0; m_mode = 0;
            m_stack.delete();
        end else if (m_mode != 1) begin
            if (run) m_mode = 1;
        end else begin
            consume = m_valid && ir_ready;
            if (consume && ret) begin
                if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                else begin m_pc = 0; m_err = 1; end
                m_valid = 0;
            end else if (consume && call) begin
                if (m_stack.size() < c_DEPTH) m_stack.push_back((m_ir_pc + 1) % c_MEM);
                else m_err = 1;
                m_pc = int'(jump_addr);
                m_valid = 0;
            end else if (consume && jump) begin
                m_pc = int'(jump_addr);
                m_valid = 0;
            end else if (consume && halt) begin
                m_valid = 0;
                m_mode = 2;
            end else if (!m_valid || ir_ready) begin
                m_ir = mem[m_pc];
                m_ir_pc = m_pc;
                m_valid = 1;
                m_pc = (m_pc + 1) % c_MEM;
            end
        end
        @(posedge clock);
        #1;
        chk("ir_valid", 32'(ir_valid), 32'(m_valid));
        chk("ir_pc", 32'(ir_pc), m_ir_pc);
        chk("ir", 32'(ir), 32'(m_ir));
        chk("address", 32'(address), m_pc);
        chk("halted", 32'(halted), 32'(m_mode != 1));
        chk("stack_err", 32'(stack_err), 32'(m_err));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic advance_to(input int target);
        int k = 0;
        while (!(ir_valid === 1'b1 && int'(ir_pc) == target) && k < 200) begin
            tick();
            k++;
        end
        chk("reach_pc", 32'(ir_pc), target);
        chk("reach_valid", 32'(ir_valid), 1);
    endtask

    initial begin
        for (int n = 0; n < c_MEM; n++) mem[n] = 25'($urandom);
        reset = 1'b1; ir_ready = 1'b1; jump = 0; call = 0; ret = 0;
        halt = 0; run = 0; jump_addr = '0;
        #1;

        // Reset state
        tick();
        do_reset();
        chk("rst_valid", 32'(ir_valid), 0);
        chk("rst_addr", 32'(address), 0);
        chk("rst_halted", 32'(halted), 1);

        // Sequential fetch through a full wrap
        pulse_run();
        chk("idle_no_fetch", 32'(ir_valid), 0);
        for (int n = 0; n <= c_MEM; n++) begin
            tick();
            chk("seq_pc", 32'(ir_pc), n % c_MEM);
            chk("seq_valid", 32'(ir_valid), 1);
        end

        // Backpressure at ir_pc=3
        do_reset();
        pulse_run();
        advance_to(3);
        ir_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("stall_pc", 32'(ir_pc), 3);
            chk("stall_valid", 32'(ir_valid), 1);
        end
        ir_ready = 1'b1;
        tick();
        chk("stall_release", 32'(ir_pc), 4);

        // Jump, call, return
        advance_to(5);
        jump = 1'b1; jump_addr = 6'd20;
        tick();
        jump = 1'b0;
        chk("jump_bubble", 32'(ir_valid), 0);
        tick();
        chk("jump_tgt", 32'(ir_pc), 20);
        advance_to(22);
        call = 1'b1; jump_addr = 6'd40;
        tick();
        call = 1'b0;
        tick();
        chk("call_tgt", 32'(ir_pc), 40);
        advance_to(41);
        ret = 1'b1;
        tick();
        ret = 1'b0;
        tick();
        chk("ret_tgt", 32'(ir_pc), 23);
        chk("ret_err", 32'(stack_err), 0);

        // Overflow: fifth nested call flags but still redirects
        for (int i = 0; i < 5; i++) begin
            call = 1'b1; jump_addr = 6'(44 + 2 * i);
            tick();
            call = 1'b0;
            chk("ovf_err", 32'(stack_err), 32'(i == 4));
            tick();
            chk("ovf_tgt", 32'(ir_pc), 44 + 2 * i);
        end

        // Underflow after reset
        do_reset();
        pulse_run();
        tick();
        ret = 1'b1;
        tick();
        ret = 1'b0;
        chk("unf_err", 32'(stack_err), 1);
        tick();
        chk("unf_pc", 32'(ir_pc), 0);

        // Halt and resume
        advance_to(10);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("halt_halted", 32'(halted), 1);
        chk("halt_valid", 32'(ir_valid), 0);
        chk("halt_addr", 32'(address), 11);
        tick();
        tick();
        chk("halt_hold", 32'(halted), 1);
        pulse_run();
        tick();
        chk("resume_pc", 32'(ir_pc), 11);

        // Redirect beats halt
        halt = 1'b1; jump = 1'b1; jump_addr = 6'd30;
        tick();
        halt = 1'b0; jump = 1'b0;
        chk("prio_halted", 32'(halted), 0);
        tick();
        chk("prio_tgt", 32'(ir_pc), 30);

        // Reset during a stall
        advance_to(7);
        ir_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; ir_ready = 1'b1;
        chk("mid_rst_valid", 32'(ir_valid), 0);
        chk("mid_rst_addr", 32'(address), 0);
        chk("mid_rst_halted", 32'(halted), 1);
        chk("mid_rst_err", 32'(stack_err), 0);
        pulse_run();
        tick();
        chk("mid_rst_restart", 32'(ir_pc), 0);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            ir_ready  = ($urandom_range(0, 3) != 0);
            jump      = ($urandom_range(0, 11) == 0);
            call      = ($urandom_range(0, 11) == 0);
            ret       = ($urandom_range(0, 11) == 0);
            halt      = ($urandom_range(0, 15) == 0);
            run       = ($urandom_range(0, 5) == 0);
            reset     = ($urandom_range(0, 199) == 0);
            jump_addr = 6'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_fetch.md
Name: prog_fetch

Overview:
Instruction fetch sequencer for the prog program memory. It owns the program counter and drives prog's combinational address input. It registers the returned instruction into an instruction register and hands it to decode over a valid/ready handshake. It handles jump, call and return redirects through a small hardware return stack, plus halt/run control.

Parameters:
p_size, 6, program address width; memory depth is 1<<p_size
i_size, 24, instruction MSB index; instruction width is i_size+1 (25 bits)
stack_depth, 4, return stack entries (power of 2, >=2)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
address  output  p_size  to prog.address; always equals pc
instr  input  i_size+1  from prog.instr; combinational read of address
ir  output  i_size+1  registered instruction to decode
ir_pc  output  p_size  address ir was fetched from
ir_valid  output  1  ir holds an instruction not yet consumed
ir_ready  input  1  decode accepts ir this cycle
jump  input  1  redirect to jump_addr; qualified by consume
call  input  1  push ir_pc+1, redirect to jump_addr; qualified by consume
ret  input  1  pop stack, redirect to popped address; qualified by consume
jump_addr  input  p_size  redirect target for jump/call
halt  input  1  stop fetching after this instruction; qualified by consume
run  input  1  start or resume fetching
halted  output  1  high in IDLE and HALTED states
stack_err  output  1  sticky flag for stack overflow or underflow; cleared only by reset

Behaviour:
- Reset values, applied at a clock edge with reset high; reset overrides all other inputs, including mid-stall:
  - pc=0, ir=0, ir_pc=0, ir_valid=0
  - sp=0 (stack empty), stack contents don't-care
  - stack_err=0, state=IDLE, halted=1
- Definitions:
  - consume = ir_valid && ir_ready
  - can_load = !ir_valid || ir_ready
- Control inputs jump, call, ret and halt are ignored unless consume is high.
- State IDLE:
  - run=1 -> FETCH; pc unchanged.
  - No fetch is performed in the transition cycle.
- State FETCH, evaluated per edge in this priority order:
  1. consume with ret:
     - sp>0: pc <= stack[sp-1]; sp <= sp-1.
     - sp==0: pc <= 0; stack_err <= 1.
     - ir_valid <= 0 (one bubble).
  2. consume with call:
     - sp<stack_depth: stack[sp] <= ir_pc+1 (mod 2^p_size); sp <= sp+1.
     - Stack full: no push; stack_err <= 1.
     - pc <= jump_addr; ir_valid <= 0.
  3. consume with jump: pc <= jump_addr; ir_valid <= 0.
  4. consume with halt: ir_valid <= 0; state <= HALTED; pc unchanged.
  5. Otherwise, if can_load:
     - ir <= instr; ir_pc <= pc; ir_valid <= 1.
     - pc <= pc+1, wrapping (1<<p_size)-1 -> 0.
  6. Otherwise (stall, ir_valid && !ir_ready): ir, ir_pc, ir_valid and pc all hold.
- Simultaneous redirect inputs resolve by the priority above. halt combined with any redirect: the redirect wins and halt is ignored.
- State HALTED:
  - ir_valid=0.
  - run=1 -> FETCH; fetch resumes at the current pc, i.e. the address after the halting instruction.
- Latency:
  - Run sampled in IDLE at edge k -> first ir_valid after edge k+1.
  - Steady state with ir_ready tied high: one instruction per cycle.
  - Redirect cost: exactly one bubble cycle; the target instruction is valid after the second edge following consume.
- address = pc combinationally at all times.
- halted = (state != FETCH).
- The stack pointer is p-bit wide, clog2(stack_depth)+1; no wrap.

Test Plan:
- Sequential fetch: prog.hex word n = n, ir_ready=1, run pulsed one cycle -> ir_pc sequence 0,1,2,...,63,0. ir equals prog_mem[ir_pc] every valid cycle, with no gaps after the first.
- Backpressure: ir_ready=0 for 5 cycles while ir_pc=3 -> ir and ir_pc stay 3 and ir_valid stays 1. Release ir_ready -> next ir_pc=4, with no skipped or duplicated address.
- Jump and call/return:
  - jump to 20 at ir_pc=5 -> one invalid cycle, then ir_pc=20.
  - call to 40 at ir_pc=22 -> then ir_pc=40.
  - ret at ir_pc=41 -> then ir_pc=23; stack_err=0.
- Stack errors:
  - 5 nested calls with stack_depth=4 -> stack_err=1 on the 5th, and the 5th still redirects to its target.
  - Separately after reset: ret with empty stack -> ir_pc=0 next, stack_err=1.
- Halt/resume and priority:
  - halt at ir_pc=10 -> halted=1, ir_valid=0, address=11.
  - run -> ir_pc=11.
  - halt+jump to 30 together at consume -> ir_pc=30, halted stays 0.
- Reset mid-operation: synchronous reset during a stall at ir_pc=7 -> next cycle ir_valid=0, address=0, halted=1, stack_err=0. Run then restarts fetching at ir_pc=0.
